// File: rtl/mipi_rx_pkt_writer_if.sv
// Lane-aligned CSI-2 word stream from the byte/lane merger into the packet writer.
// One word per cycle when valid is high; there is no backpressure.
interface mipi_rx_pkt_writer_if #(
    parameter int DW = 32
);
    logic          valid;   // data valid this cycle
    logic          sop;     // with valid: data is a packet header
    logic [DW-1:0] data;    // header {ECC, WC, DI} or four payload bytes

    modport master (output valid, sop, data);
    modport slave  (input  valid, sop, data);
endinterface

// File: rtl/mipi_rx_pkt_writer.sv
// Write-side controller for the dual-clock RX line RAM (SDP, 2**AW x 32).
// Parses lane-aligned CSI-2 packets, writes payload of the configured data type
// and publishes a Gray-coded committed write pointer once per complete line.
// Truncated or overflowing lines are discarded by rewinding the speculative
// write pointer to the last committed one.
module mipi_rx_pkt_writer #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic                 clkw,
    input  logic                 rstw,
    input  logic [5:0]           cfg_dt,
    mipi_rx_pkt_writer_if.slave  hs,
    input  logic [AW:0]          rptr_gray,
    output logic                 cew,
    output logic [AW-1:0]        aw,
    output logic [DW-1:0]        dw,
    output logic [AW:0]          wptr_gray,
    output logic                 line_done,
    output logic [AW:0]          line_words,
    output logic                 fs_pulse,
    output logic                 fe_pulse,
    output logic                 ovf_err,
    output logic                 trunc_err
);

    // Word counter width: ceil(65535 / 4) = 16384 needs 15 bits.
    localparam int LW = 15;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;

    // ------------------------------------------------------------------
    // Pointer helpers
    // ------------------------------------------------------------------
    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // NOTE: a function-local variable is fully assigned before use on every
    // call, so it never implies storage the way a partly assigned always_comb
    // variable would.
    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    // Keep bytes below the tail count of a partial last word; clear the rest.
    function automatic logic [DW-1:0] tail_mask(input logic [1:0] t);
        logic [DW-1:0] m;
        case (t)
            2'd1:    m = 32'h0000_00FF;
            2'd2:    m = 32'h0000_FFFF;
            2'd3:    m = 32'h00FF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state;
    logic [AW:0]   cp;            // committed write pointer (binary)
    logic [AW:0]   wa;            // speculative write pointer (binary)
    logic [LW-1:0] left;          // payload words still expected
    logic [1:0]    tail;          // WC[1:0] of the current line
    logic [AW:0]   line_len;      // ceil(WC/4) of the current line
    logic          commit_pend;   // last word written, pointer publish next cycle
    logic [AW:0]   commit_ptr;    // pointer value to publish

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [AW:0]   rptr_bin;
    logic          full;
    logic [5:0]    hdr_dt;
    logic [15:0]   hdr_wc;
    logic [16:0]   hdr_wc_p3;
    logic [LW-1:0] hdr_words;
    logic          hdr_capture;
    logic          last_word;
    logic [AW:0]   cp_eff;

    assign rptr_bin  = gray2bin(rptr_gray);
    assign full      = (wa - rptr_bin) == {1'b1, {AW{1'b0}}};

    assign hdr_dt    = hs.data[5:0];
    assign hdr_wc    = hs.data[23:8];
    assign hdr_wc_p3 = {1'b0, hdr_wc} + 17'd3;
    assign hdr_words = hdr_wc_p3[16:2];

    // Long packet of the selected type carrying at least one byte.
    assign hdr_capture = (hdr_dt >= DT_LONG_MIN) && (hdr_dt == cfg_dt) && (hdr_wc != 16'd0);

    assign last_word = (left == LW'(1));

    // A header arriving right after a line's last word must rewind to the
    // pointer that is about to be committed, not the stale one.
    assign cp_eff = commit_pend ? commit_ptr : cp;

    // ------------------------------------------------------------------
    // Packet FSM, RAM write port and pointer publication
    // ------------------------------------------------------------------
    // NOTE: every register here is assigned with <= so all right-hand sides
    // see the pre-edge values; blocking assignments would make results
    // depend on statement order.
    always_ff @(posedge clkw) begin
        if (rstw) begin
            state       <= IDLE;
            cp          <= '0;
            wa          <= '0;
            left        <= '0;
            tail        <= '0;
            line_len    <= '0;
            commit_pend <= 1'b0;
            commit_ptr  <= '0;
            cew         <= 1'b0;
            aw          <= '0;
            dw          <= '0;
            wptr_gray   <= '0;
            line_done   <= 1'b0;
            line_words  <= '0;
            fs_pulse    <= 1'b0;
            fe_pulse    <= 1'b0;
            ovf_err     <= 1'b0;
            trunc_err   <= 1'b0;
        end else begin
            // Single-cycle strobes default low and are raised below.
            cew       <= 1'b0;
            line_done <= 1'b0;
            fs_pulse  <= 1'b0;
            fe_pulse  <= 1'b0;

            // Publish the pointer one cycle after the last RAM write so the
            // data is in the RAM before the reader can see it.
            if (commit_pend) begin
                commit_pend <= 1'b0;
                cp          <= commit_ptr;
                wptr_gray   <= bin2gray(commit_ptr);
                line_done   <= 1'b1;
                line_words  <= line_len;
            end

            if (hs.valid && hs.sop) begin
                // Header: abandons any line in progress, then decodes as new.
                if (state == PAYLOAD) begin
                    trunc_err <= 1'b1;
                end
                wa    <= cp_eff;
                state <= IDLE;
                if (hdr_dt == DT_FS) begin
                    fs_pulse <= 1'b1;
                end else if (hdr_dt == DT_FE) begin
                    fe_pulse <= 1'b1;
                end else if (hdr_capture) begin
                    left     <= hdr_words;
                    tail     <= hdr_wc[1:0];
                    line_len <= hdr_words[AW:0];
                    state    <= PAYLOAD;
                end
            end else if (hs.valid && (state == PAYLOAD)) begin
                if (full) begin
                    // No room: drop the whole line.
                    ovf_err <= 1'b1;
                    wa      <= cp;
                    state   <= IDLE;
                end else begin
                    cew  <= 1'b1;
                    aw   <= wa[AW-1:0];
                    dw   <= last_word ? (hs.data & tail_mask(tail)) : hs.data;
                    wa   <= wa + (AW + 1)'(1);
                    left <= left - LW'(1);
                    if (last_word) begin
                        commit_pend <= 1'b1;
                        commit_ptr  <= wa + (AW + 1)'(1);
                        state       <= IDLE;
                    end
                end
            end
        end
    end

endmodule
